// File: rtl/entry_history_reg_pkg.sv
// rtl/entry_history_reg_pkg.sv - shared constants and operation encoding for entry_history_reg
//
// Contents:
//   ENTRY_WIDTH_DEF / ENTRY_DEPTH_DEF / ENTRY_MAX_DEF : default parameter values
//   op_t : the single per-cycle operation chosen by the priority decode
package entry_hist_pkg;

    localparam int ENTRY_WIDTH_DEF = 14;
    localparam int ENTRY_DEPTH_DEF = 4;
    localparam int ENTRY_MAX_DEF   = 9999;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_SET,
        OP_PUSH,
        OP_POP
    } op_t;

endpackage

// File: rtl/entry_history_reg_rise_det.sv
// rtl/entry_history_reg_rise_det.sv - rising-edge detector for a debounced level input
//
// Ports:
//   clk  : clock
//   clr  : synchronous active-high clear; masks the edge output while asserted
//   in   : level input
//   rise : high for the cycle in which in is high and was low on the previous edge
module rise_det (
    input  logic clk,
    input  logic clr,
    input  logic in,
    output logic rise
);

    logic in_q;

    // The history flop is loaded every cycle, clr included, so a button held
    // across clr is already "seen" and cannot fire when clr drops.
    always_ff @(posedge clk) begin
        in_q <= in;
    end

    assign rise = in & ~in_q & ~clr;

endmodule

// File: rtl/entry_history_reg.sv
// rtl/entry_history_reg.sv - DEPTH-deep LIFO history of entered values with undo
//
// Parameters:
//   WIDTH   : data width of each entry
//   DEPTH   : number of stored entries (>= 2)
//   MAX_VAL : clamp ceiling for pushed values, applied only with ENTRY_CLAMP_EN defined
// Macro:
//   ENTRY_CLAMP_EN : when defined, a pushed D above MAX_VAL is stored as MAX_VAL
// Ports:
//   clk      : clock, all state updates on posedge
//   clr      : synchronous active-high clear of all entries
//   D        : value stored on an enter edge
//   enter    : level; rising edge pushes D
//   undo     : level; rising edge pops the top entry
//   set      : level; every cycle high forces the top entry to all ones
//   Q        : top (most recent) entry, 0 when empty
//   count    : number of valid entries
//   empty    : count == 0
//   full     : count == DEPTH
//   overflow : one-cycle pulse after a push that discarded the oldest entry
module entry_history_reg
    import entry_hist_pkg::*;
#(
    parameter int WIDTH   = ENTRY_WIDTH_DEF,
    parameter int DEPTH   = ENTRY_DEPTH_DEF,
    parameter int MAX_VAL = ENTRY_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           D,
    input  logic                       enter,
    input  logic                       undo,
    input  logic                       set,
    output logic [WIDTH-1:0]           Q,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

`ifdef ENTRY_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic             enter_rise;
    logic             undo_rise;
    logic [WIDTH-1:0] push_val;
    op_t              op;

    rise_det u_enter_rise (
        .clk  (clk),
        .clr  (clr),
        .in   (enter),
        .rise (enter_rise)
    );

    rise_det u_undo_rise (
        .clk  (clk),
        .clr  (clr),
        .in   (undo),
        .rise (undo_rise)
    );

    // Unsigned compare on WIDTH bits; set bypasses this path and stays all ones.
    assign push_val = (CLAMP_EN && (D > MAX_W)) ? MAX_W : D;

    // Exactly one operation per cycle; lower-priority edges are dropped.
    always_comb begin
        op = OP_NONE;
        if (clr) begin
            op = OP_CLR;
        end else if (set) begin
            op = OP_SET;
        end else if (enter_rise) begin
            op = OP_PUSH;
        end else if (undo_rise) begin
            op = OP_POP;
        end
    end

    always_ff @(posedge clk) begin
        overflow <= 1'b0;
        case (op)
            OP_CLR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                count <= '0;
            end
            OP_SET: begin
                mem[0] <= '1;
                if (count == '0) begin
                    count <= CW'(1);
                end
            end
            OP_PUSH: begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    mem[i] <= mem[i-1];
                end
                mem[0] <= push_val;
                if (count == CW'(DEPTH)) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
            OP_POP: begin
                if (count != '0) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        mem[i] <= mem[i+1];
                    end
                    // Keeps the invariant that invalid slots read as 0.
                    mem[DEPTH-1] <= '0;
                    count        <= count - CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign Q     = mem[0];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_entry_history_reg.sv
// tb/tb_entry_history_reg.sv - scoreboard bench for entry_history_reg
module tb_entry_history_reg;

    localparam int W  = 14;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);
    localparam logic [W-1:0] ONES = 14'd16383;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [W-1:0]  d = '0;
    logic          enter = 1'b0;
    logic          undo = 1'b0;
    logic          set = 1'b0;
    logic [W-1:0]  q;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;

    entry_history_reg #(.WIDTH(W), .DEPTH(DP), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .clr      (clr),
        .D        (d),
        .enter    (enter),
        .undo     (undo),
        .set      (set),
        .Q        (q),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          ov;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int stp, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, stp, act, req);
        end
    endtask

    // Monitor: compares the DUT against the expectation scheduled for this cycle.
    exp_t e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("Q",        e.cyc, int'(q),        int'(e.q));
                chk("count",    e.cyc, int'(count),    int'(e.cnt));
                chk("empty",    e.cyc, int'(empty),    int'(e.cnt == '0));
                chk("full",     e.cyc, int'(full),     int'(e.cnt == CW'(DP)));
                chk("overflow", e.cyc, int'(overflow), int'(e.ov));
            end else if (sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL stale_expectation cycle %0d: got none expected check at %0d", cyc, e.cyc);
            end
        end
    end

    // Drive one cycle of inputs and schedule the state expected after the next edge.
    task automatic step(input logic c, input logic s, input logic en, input logic un,
                        input int dv, input int eq, input int ecnt, input logic eov);
        exp_t x;
        @(posedge clk);
        #1;
        clr   = c;
        set   = s;
        enter = en;
        undo  = un;
        d     = W'(dv);
        x.cyc = cyc + 1;
        x.q   = W'(eq);
        x.cnt = CW'(ecnt);
        x.ov  = eov;
        sb.push_back(x);
        step_no++;
    endtask

    // Push with a following release cycle.
    task automatic push(input int dv, input int eq, input int ecnt, input logic eov);
        step(0, 0, 1, 0, dv, eq, ecnt, eov);
        step(0, 0, 0, 0, 0, eq, ecnt, 1'b0);
    endtask

    task automatic pop(input int eq, input int ecnt);
        step(0, 0, 0, 1, 0, eq, ecnt, 1'b0);
        step(0, 0, 0, 0, 0, eq, ecnt, 1'b0);
    endtask

    initial begin
        int clamp_exp;
`ifdef ENTRY_CLAMP_EN
        clamp_exp = 9999;
`else
        clamp_exp = 12000;
`endif
        // Reset with enter held high: no push until enter goes low then high.
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 5, 0, 0, 0);

        // Fill, overflow, drain.
        push(1, 1, 1, 0);
        push(2, 2, 2, 0);
        push(3, 3, 3, 0);
        push(4, 4, 4, 0);
        push(5, 5, 4, 1);
        pop(4, 3);
        pop(3, 2);
        pop(2, 1);
        pop(0, 0);

        // Pop when empty, then set when empty.
        pop(0, 0);
        step(0, 1, 0, 0, 0, ONES, 1, 0);
        step(0, 0, 0, 0, 0, ONES, 1, 0);

        // Stack [3], then enter and undo rising together: push wins.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        push(3, 3, 1, 0);
        step(0, 0, 1, 1, 7, 7, 2, 0);
        step(0, 0, 0, 0, 0, 7, 2, 0);
        pop(3, 1);
        push(7, 7, 2, 0);

        // set + enter together: top forced to ones, count unchanged, deeper kept.
        step(0, 1, 1, 0, 9, ONES, 2, 0);
        step(0, 0, 0, 0, 0, ONES, 2, 0);
        pop(3, 1);

        // set held while undo rises: undo dropped.
        step(0, 1, 0, 1, 0, ONES, 1, 0);
        step(0, 0, 0, 0, 0, ONES, 1, 0);

        // Clamp (or verbatim store).
        step(1, 0, 0, 0, 0, 0, 0, 0);
        push(12000, clamp_exp, 1, 0);

        // Mid-operation reset at count=3 together with an enter edge.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1, 1, 0);
        push(2, 2, 2, 0);
        push(3, 3, 3, 0);
        step(1, 0, 1, 0, 9, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        push(6, 6, 1, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
